// File: rtl/mode_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// mode_cmd_scheduler
//
// Central controller between the user inputs (debounced buttons, UART
// receiver) and the four function blocks (stopwatch, watch, SR04, DHT11).
// It merges button pulses and UART command bytes into one registered command
// stream, holds the active mode, and runs the measurement scheduler: manual
// or auto-periodic start pulses, a start/busy handshake and a busy timeout.
//
// Optional feature macro: UART_UPPER_EN
//   defined   : uppercase 'R','U','D','L','M','S' decode like lowercase.
//   undefined : uppercase bytes are ignored like any unknown byte.
//
// Parameters
//   CLK_HZ          system clock frequency, used to derive the 1 ms step
//   AUTO_PERIOD_MS  auto-run interval between sensor starts
//   BUSY_TIMEOUT_MS maximum wait for sensor_busy to rise or to fall
//
// Ports
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   btn_u/d/l/r_i    debounced single-cycle button pulses
//   mode_sw_i        0 = mode-select, 1 = command
//   rx_data_i        UART byte, qualified by rx_valid_i
//   rx_valid_i       single-cycle strobe for rx_data_i
//   sensor_busy_i    busy flag of the sensor selected by the mode
//   send_ack_i       UART sender accepted the send request
//   mode_o           0 stopwatch, 1 watch, 2 sr04, 3 dht11
//   cmd_run/up/down/clear_o  single-cycle commands to stopwatch/watch
//   sr04_start_o     single-cycle SR04 measurement start
//   dht11_start_o    single-cycle DHT11 measurement start
//   auto_on_o        auto-run enabled
//   send_req_o       level, held until send_ack_i
//   sensor_err_o     single-cycle pulse on handshake timeout
//   rx_drop_o        single-cycle pulse when a UART byte is discarded
//
// Every output is registered: an event in cycle N is visible in cycle N+1.
// ---------------------------------------------------------------------------
module mode_cmd_scheduler #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int AUTO_PERIOD_MS  = 1000,
    parameter int BUSY_TIMEOUT_MS = 50
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_u_i,
    input  logic       btn_d_i,
    input  logic       btn_l_i,
    input  logic       btn_r_i,
    input  logic       mode_sw_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    input  logic       sensor_busy_i,
    input  logic       send_ack_i,
    output logic [1:0] mode_o,
    output logic       cmd_run_o,
    output logic       cmd_up_o,
    output logic       cmd_down_o,
    output logic       cmd_clear_o,
    output logic       sr04_start_o,
    output logic       dht11_start_o,
    output logic       auto_on_o,
    output logic       send_req_o,
    output logic       sensor_err_o,
    output logic       rx_drop_o
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int CYC_PER_MS = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int PRE_W      = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam int AUTO_W     = $clog2(AUTO_PERIOD_MS + 1);
    localparam int TO_W       = $clog2(BUSY_TIMEOUT_MS + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CYC_PER_MS - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD_MS - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BUSY_TIMEOUT_MS - 1);

    // Sensor handshake FSM
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_BUSY    = 2'd3;

    // Decoded UART command codes
    localparam logic [2:0] DC_NONE  = 3'd0;
    localparam logic [2:0] DC_RUN   = 3'd1;
    localparam logic [2:0] DC_UP    = 3'd2;
    localparam logic [2:0] DC_DOWN  = 3'd3;
    localparam logic [2:0] DC_CLEAR = 3'd4;
    localparam logic [2:0] DC_MODE  = 3'd5;
    localparam logic [2:0] DC_SEND  = 3'd6;

    function automatic logic [2:0] decode_byte(input logic [7:0] b);
        logic [2:0] code;
        case (b)
            8'h72:   code = DC_RUN;
            8'h75:   code = DC_UP;
            8'h64:   code = DC_DOWN;
            8'h6C:   code = DC_CLEAR;
            8'h6D:   code = DC_MODE;
            8'h73:   code = DC_SEND;
`ifdef UART_UPPER_EN
            8'h52:   code = DC_RUN;
            8'h55:   code = DC_UP;
            8'h44:   code = DC_DOWN;
            8'h4C:   code = DC_CLEAR;
            8'h4D:   code = DC_MODE;
            8'h53:   code = DC_SEND;
`endif
            default: code = DC_NONE;
        endcase
        return code;
    endfunction

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    logic [1:0]        mode_q,       mode_d;
    logic              auto_on_q,    auto_on_d;
    logic              send_req_q,   send_req_d;
    logic              pend_full_q,  pend_full_d;
    logic [7:0]        pend_data_q,  pend_data_d;
    logic [1:0]        fsm_q,        fsm_d;
    logic [PRE_W-1:0]  auto_pre_q,   auto_pre_d;
    logic [AUTO_W-1:0] auto_ms_q,    auto_ms_d;
    logic [PRE_W-1:0]  to_pre_q,     to_pre_d;
    logic [TO_W-1:0]   to_ms_q,      to_ms_d;

    logic cmd_run_q,     cmd_run_d;
    logic cmd_up_q,      cmd_up_d;
    logic cmd_down_q,    cmd_down_d;
    logic cmd_clear_q,   cmd_clear_d;
    logic sr04_start_q,  sr04_start_d;
    logic dht11_start_q, dht11_start_d;
    logic sensor_err_q,  sensor_err_d;
    logic rx_drop_q,     rx_drop_d;

    // -----------------------------------------------------------------------
    // Command merge: buttons win, UART byte waits in a 1-deep pending slot
    // -----------------------------------------------------------------------
    logic       btn_any;
    logic       uart_issue;
    logic [7:0] uart_byte;
    logic [2:0] uart_code;
    logic       ev_mode, ev_run, ev_up, ev_down, ev_clear, ev_send;
    logic       sensor_mode;
    logic       meas_req;
    logic       auto_toggle;
    logic       auto_tick;
    logic       to_expire;

    assign btn_any     = btn_u_i | btn_d_i | btn_l_i | btn_r_i;
    // A byte is issued either from the pending slot or straight from the
    // receiver when nothing is pending; never in a cycle with a button pulse.
    assign uart_issue  = !btn_any && (pend_full_q || rx_valid_i);
    assign uart_byte   = pend_full_q ? pend_data_q : rx_data_i;
    assign uart_code   = uart_issue ? decode_byte(uart_byte) : DC_NONE;

    assign ev_mode     = (btn_r_i && !mode_sw_i) || (uart_code == DC_MODE);
    assign ev_run      = (btn_r_i &&  mode_sw_i) || (uart_code == DC_RUN);
    assign ev_up       = (btn_u_i &&  mode_sw_i) || (uart_code == DC_UP);
    assign ev_down     = (btn_d_i &&  mode_sw_i) || (uart_code == DC_DOWN);
    assign ev_clear    = (btn_l_i &&  mode_sw_i) || (uart_code == DC_CLEAR);
    assign ev_send     = (uart_code == DC_SEND);

    // Modes 2 and 3 are the sensor modes; there run/up are re-purposed.
    assign sensor_mode = mode_q[1];
    assign meas_req    = ev_run && sensor_mode;
    assign auto_toggle = ev_up && sensor_mode;

    assign auto_tick   = auto_on_q && sensor_mode &&
                         (auto_pre_q == PRE_LAST) && (auto_ms_q == AUTO_LAST);
    assign to_expire   = (to_pre_q == PRE_LAST) && (to_ms_q == TO_LAST);

    always_comb begin
        pend_full_d = pend_full_q;
        pend_data_d = pend_data_q;
        rx_drop_d   = rx_valid_i && pend_full_q;
        if (pend_full_q) begin
            if (!btn_any) begin
                pend_full_d = 1'b0;
            end
        end else if (rx_valid_i && btn_any) begin
            pend_full_d = 1'b1;
            pend_data_d = rx_data_i;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath commands, send request
    // -----------------------------------------------------------------------
    always_comb begin
        cmd_run_d   = ev_run   && !sensor_mode;
        cmd_up_d    = ev_up    && !sensor_mode;
        cmd_down_d  = ev_down  && !sensor_mode;
        cmd_clear_d = ev_clear && !sensor_mode;

        send_req_d = send_req_q;
        if (send_req_q && send_ack_i) begin
            send_req_d = 1'b0;
        end else if (ev_send) begin
            send_req_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Mode, auto-run enable and auto period counter
    // -----------------------------------------------------------------------
    always_comb begin
        mode_d     = mode_q;
        auto_on_d  = auto_on_q;
        auto_pre_d = auto_pre_q;
        auto_ms_d  = auto_ms_q;
        if (ev_mode) begin
            mode_d     = mode_q + 2'd1;
            auto_on_d  = 1'b0;
            auto_pre_d = '0;
            auto_ms_d  = '0;
        end else if (auto_toggle) begin
            // Turning on restarts a full period; turning off parks at zero.
            auto_on_d  = !auto_on_q;
            auto_pre_d = '0;
            auto_ms_d  = '0;
        end else if (auto_on_q) begin
            if (auto_pre_q == PRE_LAST) begin
                auto_pre_d = '0;
                auto_ms_d  = (auto_ms_q == AUTO_LAST) ? '0 : auto_ms_q + 1'b1;
            end else begin
                auto_pre_d = auto_pre_q + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sensor handshake FSM with timeout
    // -----------------------------------------------------------------------
    always_comb begin
        fsm_d         = fsm_q;
        sr04_start_d  = 1'b0;
        dht11_start_d = 1'b0;
        sensor_err_d  = 1'b0;
        if (ev_mode) begin
            // Mode change abandons any measurement without a start pulse.
            fsm_d = ST_IDLE;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    // A tick lost while not idle is simply dropped here.
                    if (meas_req || auto_tick) begin
                        fsm_d         = ST_START;
                        sr04_start_d  = (mode_q == 2'd2);
                        dht11_start_d = (mode_q == 2'd3);
                    end
                end
                ST_START: begin
                    fsm_d = ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (sensor_busy_i) begin
                        fsm_d = ST_BUSY;
                    end else if (to_expire) begin
                        fsm_d        = ST_IDLE;
                        sensor_err_d = 1'b1;
                    end
                end
                default: begin
                    if (!sensor_busy_i) begin
                        fsm_d = ST_IDLE;
                    end else if (to_expire) begin
                        fsm_d        = ST_IDLE;
                        sensor_err_d = 1'b1;
                    end
                end
            endcase
        end

        // Timeout counter restarts on every state entry and only runs
        // while waiting on the sensor.
        to_pre_d = '0;
        to_ms_d  = '0;
        if ((fsm_d == fsm_q) && ((fsm_q == ST_WAIT_HI) || (fsm_q == ST_BUSY))) begin
            if (to_pre_q == PRE_LAST) begin
                to_pre_d = '0;
                to_ms_d  = to_ms_q + 1'b1;
            end else begin
                to_pre_d = to_pre_q + 1'b1;
                to_ms_d  = to_ms_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q        <= 2'd0;
            auto_on_q     <= 1'b0;
            send_req_q    <= 1'b0;
            pend_full_q   <= 1'b0;
            pend_data_q   <= 8'h00;
            fsm_q         <= ST_IDLE;
            auto_pre_q    <= '0;
            auto_ms_q     <= '0;
            to_pre_q      <= '0;
            to_ms_q       <= '0;
            cmd_run_q     <= 1'b0;
            cmd_up_q      <= 1'b0;
            cmd_down_q    <= 1'b0;
            cmd_clear_q   <= 1'b0;
            sr04_start_q  <= 1'b0;
            dht11_start_q <= 1'b0;
            sensor_err_q  <= 1'b0;
            rx_drop_q     <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            auto_on_q     <= auto_on_d;
            send_req_q    <= send_req_d;
            pend_full_q   <= pend_full_d;
            pend_data_q   <= pend_data_d;
            fsm_q         <= fsm_d;
            auto_pre_q    <= auto_pre_d;
            auto_ms_q     <= auto_ms_d;
            to_pre_q      <= to_pre_d;
            to_ms_q       <= to_ms_d;
            cmd_run_q     <= cmd_run_d;
            cmd_up_q      <= cmd_up_d;
            cmd_down_q    <= cmd_down_d;
            cmd_clear_q   <= cmd_clear_d;
            sr04_start_q  <= sr04_start_d;
            dht11_start_q <= dht11_start_d;
            sensor_err_q  <= sensor_err_d;
            rx_drop_q     <= rx_drop_d;
        end
    end

    assign mode_o        = mode_q;
    assign cmd_run_o     = cmd_run_q;
    assign cmd_up_o      = cmd_up_q;
    assign cmd_down_o    = cmd_down_q;
    assign cmd_clear_o   = cmd_clear_q;
    assign sr04_start_o  = sr04_start_q;
    assign dht11_start_o = dht11_start_q;
    assign auto_on_o     = auto_on_q;
    assign send_req_o    = send_req_q;
    assign sensor_err_o  = sensor_err_q;
    assign rx_drop_o     = rx_drop_q;

endmodule
